// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and the default bit divider.
// Used by uart_rx_fifo; the transmit path is expected to import the same package.
package uart_pkg;

    // 100 MHz / 115200 baud, rounded
    localparam int unsigned CLKS_PER_BIT_115200_100MHZ = 868;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with a sticky overflow flag.
// Pointers carry one extra MSB so full and empty are distinguishable.
module sync_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [DATA_BITS-1:0]          i_push_data,
    input  logic                          i_pop,
    input  logic                          i_clr_ovf,
    output logic [DATA_BITS-1:0]          o_head,
    output logic                          o_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW:0]          r_wr_ptr;
    logic [AW:0]          r_rd_ptr;
    logic                 r_overflow;

    logic [AW:0] w_count;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_wr;
    logic        w_drop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign w_wr    = i_push && (!w_full || w_pop);
    assign w_drop  = i_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_valid    = !w_empty;
    assign o_count    = w_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (start + DATA_BITS + optional even parity + stop) feeding a FWFT FIFO.
// Define UART_RX_PARITY_EN to add the parity bit and the parity_err output.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200_100MHZ,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rxd,
    output logic [DATA_BITS-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    output logic                        frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                        parity_err,
`endif
    input  logic                        clr_err
);

    localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LAST_BIT  = 4'(DATA_BITS - 1);

    logic r_sync1;
    logic r_sync2;
    logic r_rx_prev;
    logic w_rx;

    uart_rx_state_e       r_state;
    logic [15:0]          r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_push;
    logic [DATA_BITS-1:0] r_push_data;
    logic                 r_frame_err;
`ifdef UART_RX_PARITY_EN
    logic                 r_par_bad;
    logic                 r_parity_err;
`endif

    // Synchronizer idles high so reset never looks like a start edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= rxd;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    assign w_rx = r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_push_data <= '0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    // Edge-triggered: a held-low line (break) cannot re-arm until it goes high
                    if (r_rx_prev && !w_rx) begin
                        r_state <= StStart;
                        r_cnt   <= HALF_LOAD;
                    end
                end
                StStart: begin
                    if (r_cnt == '0) begin
                        if (!w_rx) begin
                            r_state   <= StData;
                            r_cnt     <= FULL_LOAD;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                StData: begin
                    if (r_cnt == '0) begin
                        r_shift <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= FULL_LOAD;
                        if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= StParity;
`else
                            r_state <= StStop;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (r_cnt == '0) begin
                        r_par_bad    <= (^r_shift) != w_rx;
                        r_parity_err <= (^r_shift) != w_rx;
                        r_cnt        <= FULL_LOAD;
                        r_state      <= StStop;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                StStop: begin
                    if (r_cnt == '0) begin
                        if (w_rx) begin
`ifdef UART_RX_PARITY_EN
                            r_push <= !r_par_bad;
`else
                            r_push <= 1'b1;
`endif
                            r_push_data <= r_shift;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    sync_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_push),
        .i_push_data (r_push_data),
        .i_pop       (out_ready),
        .i_clr_ovf   (clr_err),
        .o_head      (out_data),
        .o_valid     (out_valid),
        .o_count     (fifo_count),
        .o_overflow  (overflow)
    );

    assign frame_err = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks/bit, 8 data bits, 4-entry FIFO.
// Serial stimulus changes on falling clock edges; outputs are sampled there too.
module tb_uart_rx_fifo;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          rxd       = 1'b1;
    logic          out_ready = 1'b0;
    logic          clr_err   = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          frame_err;

    int n_checks  = 0;
    int n_errors  = 0;
    int fe_pulses = 0;
    int min_cnt   = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) fe_pulses++;
    end

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DW),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Push of this frame lands on the 156th rising edge after the start bit begins,
    // so a pop requested at stop-bit cycle 11 coincides with it.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit = 1'b1,
                              input logic pop_at_push = 1'b0);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd     = stop_bit;
        min_cnt = 8;
        for (int j = 0; j < CPB; j++) begin
            if (pop_at_push) out_ready = (j == 11);
            @(negedge clk);
            if (int'(fifo_count) < min_cnt) min_cnt = int'(fifo_count);
        end
        out_ready = 1'b0;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, " valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, " data"}, 32'(out_data), 32'd0);
        check_eq({tag, " count"}, 32'(fifo_count), 32'd0);
        check_eq({tag, " overflow"}, 32'(overflow), 32'd0);
        check_eq({tag, " frame_err"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_order [4];
        exp_order[0] = 8'h02;
        exp_order[1] = 8'h03;
        exp_order[2] = 8'h04;
        exp_order[3] = 8'h07;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame, then pop
        send_frame(8'h41);
        check_eq("0x41 valid", 32'(out_valid), 32'd1);
        check_eq("0x41 data", 32'(out_data), 32'h41);
        check_eq("0x41 count", 32'(fifo_count), 32'd1);
        pop_one();
        check_eq("0x41 pop count", 32'(fifo_count), 32'd0);
        check_eq("0x41 pop valid", 32'(out_valid), 32'd0);

        // Overflow: six frames into four entries
        for (int i = 1; i <= 6; i++) send_frame(8'(i));
        check_eq("ovf count", 32'(fifo_count), 32'd4);
        check_eq("ovf flag", 32'(overflow), 32'd1);
        check_eq("ovf head", 32'(out_data), 32'h01);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check_eq("clr_err overflow", 32'(overflow), 32'd0);
        check_eq("clr_err count", 32'(fifo_count), 32'd4);

        // Push and pop in the same cycle while full
        send_frame(8'h07, 1'b1, 1'b1);
        check_eq("full push+pop min count", 32'(min_cnt), 32'd4);
        check_eq("full push+pop count", 32'(fifo_count), 32'd4);
        check_eq("full push+pop overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("order %0d", i), 32'(out_data), 32'(exp_order[i]));
            pop_one();
        end
        check_eq("drained count", 32'(fifo_count), 32'd0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check_eq("pop empty count", 32'(fifo_count), 32'd0);
        check_eq("pop empty valid", 32'(out_valid), 32'd0);

        // Short low glitch on idle line
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("glitch count", 32'(fifo_count), 32'd0);
        check_eq("glitch frame_err", 32'(fe_pulses), 32'd0);
        send_frame(8'h5A);
        check_eq("after glitch data", 32'(out_data), 32'h5A);
        check_eq("after glitch count", 32'(fifo_count), 32'd1);
        pop_one();

        // Bad stop bit, line then held low as a break
        send_frame(8'h55, 1'b0);
        repeat (100) @(negedge clk);
        check_eq("break frame_err pulses", 32'(fe_pulses), 32'd1);
        check_eq("break count", 32'(fifo_count), 32'd0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h33);
        check_eq("after break data", 32'(out_data), 32'h33);
        check_eq("after break count", 32'(fifo_count), 32'd1);
        check_eq("after break pulses", 32'(fe_pulses), 32'd1);

        // Reset during data bit 3 of 0xA5 with a byte still queued
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
        rxd = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rxd   = 1'b1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid-frame reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("post reset count", 32'(fifo_count), 32'd0);
        send_frame(8'h3C);
        check_eq("post reset data", 32'(out_data), 32'h3C);
        check_eq("post reset count 1", 32'(fifo_count), 32'd1);
        check_eq("post reset valid", 32'(out_valid), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
